// File: rtl/dr_mem_if.sv
// dr_mem_if -- memory-bus interface stage feeding the data register (DR).
//
// Takes single read/write requests from the control unit, runs a req/ack
// handshake with memory, and on a completed read presents the word on
// dr_data together with a one-cycle dr_ld strobe (DR loads on that cycle).
// A completed write reports done only.
//
// Handshake: the strobe (mem_rd or mem_wr) rises after the edge that
// accepts a request and is held until an edge that samples mem_ack=1. That
// same edge drops the strobe, returns to IDLE and schedules a one-cycle done
// (plus dr_ld for reads) in the following cycle. Requests are only looked at
// in IDLE, and mem_ack is only looked at while waiting.
//
// Optional feature, enabled by defining DR_MEM_IF_TIMEOUT_EN:
//   an 8-bit wait counter aborts a transfer after TIMEOUT wait cycles without
//   ack (err pulses for one cycle). Without the macro the block waits forever,
//   err is tied low and no counter exists.
//
// Parameters: DW data width, AW address width, TIMEOUT abort wait (2..255).
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   rd_req, wr_req        requests (read wins if both are high)
//   addr_in, wr_data      request address / write data
//   busy, done, err       status: not-IDLE, success pulse, timeout pulse
//   mem_addr, mem_wdata   latched address / write data to memory
//   mem_rd, mem_wr        strobes, held until ack
//   mem_rdata, mem_ack    memory read data and acknowledge
//   dr_data, dr_ld        registered read word and DR load strobe
module dr_mem_if #(
  parameter int DW      = 16,
  parameter int AW      = 12,
  parameter int TIMEOUT = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_req,
  input  logic          wr_req,
  input  logic [AW-1:0] addr_in,
  input  logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [DW-1:0] dr_data,
  output logic          dr_ld
);

  // Elaboration-time guard: the wait counter is 8 bits wide.
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("dr_mem_if: TIMEOUT must be in 2..255");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wdata_d;
  logic [DW-1:0] dr_data_d;
  logic          mem_rd_d, mem_wr_d;
  logic          done_d, dr_ld_d;
  logic          timeout_hit;

`ifdef DR_MEM_IF_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       err_q, err_d;

  // Counter holds the number of ack-less wait edges already seen; the edge
  // that finds it at TIMEOUT-1 ends the TIMEOUT-th wait cycle.
  assign timeout_hit = (wait_cnt_q == TO_LAST);
  assign err         = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // busy comes straight from the state register, so it stays registered.
  assign busy = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    dr_data_d   = dr_data;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    done_d      = 1'b0;
    dr_ld_d     = 1'b0;
`ifdef DR_MEM_IF_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    err_d       = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (rd_req) begin
          // Read has priority; a simultaneous write is dropped.
          state_d    = RD_WAIT;
          mem_addr_d = addr_in;
          mem_rd_d   = 1'b1;
`ifdef DR_MEM_IF_TIMEOUT_EN
          wait_cnt_d = 8'd0;
`endif
        end else if (wr_req) begin
          state_d     = WR_WAIT;
          mem_addr_d  = addr_in;
          mem_wdata_d = wr_data;
          mem_wr_d    = 1'b1;
`ifdef DR_MEM_IF_TIMEOUT_EN
          wait_cnt_d  = 8'd0;
`endif
        end
      end

      RD_WAIT: begin
        // Ack is checked before the timeout so a late ack still completes.
        if (mem_ack) begin
          state_d   = IDLE;
          dr_data_d = mem_rdata;
          dr_ld_d   = 1'b1;
          done_d    = 1'b1;
        end else if (timeout_hit) begin
          state_d = IDLE;
`ifdef DR_MEM_IF_TIMEOUT_EN
          err_d   = 1'b1;
`endif
        end else begin
          mem_rd_d = 1'b1;
`ifdef DR_MEM_IF_TIMEOUT_EN
          wait_cnt_d = wait_cnt_q + 8'd1;
`endif
        end
      end

      WR_WAIT: begin
        if (mem_ack) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (timeout_hit) begin
          state_d = IDLE;
`ifdef DR_MEM_IF_TIMEOUT_EN
          err_d   = 1'b1;
`endif
        end else begin
          mem_wr_d = 1'b1;
`ifdef DR_MEM_IF_TIMEOUT_EN
          wait_cnt_d = wait_cnt_q + 8'd1;
`endif
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      dr_data   <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      done      <= 1'b0;
      dr_ld     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      dr_data   <= dr_data_d;
      mem_rd    <= mem_rd_d;
      mem_wr    <= mem_wr_d;
      done      <= done_d;
      dr_ld     <= dr_ld_d;
    end
  end

`ifdef DR_MEM_IF_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end
`endif

endmodule

// File: doc/dr_mem_if.md
# dr_mem_if

Memory-bus interface stage directly upstream of the data register (DR). Accepts single read/write requests from the control unit, runs a req/ack handshake with the memory, and on a completed read delivers the word on `dr_data` with a one-cycle `dr_ld` strobe. The DR's load input connects to this block; DR loads on the cycle `dr_ld` is high. Completed writes report `done` only.

## Interface
Parameters:
- `DW`, 16: data width in bits.
- `AW`, 12: address width in bits.
- `TIMEOUT`, 8: wait cycles before abort, when the timeout feature is compiled in; legal range 2..255.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rd_req`  in  1  read request; sampled in IDLE only.
- `wr_req`  in  1  write request; sampled in IDLE only.
- `addr_in`  in  AW  request address.
- `wr_data`  in  DW  write data.
- `busy`  out  1  high while state is not IDLE.
- `done`  out  1  one-cycle pulse on successful completion.
- `err`  out  1  one-cycle pulse on timeout abort.
- `mem_addr`  out  AW  latched address.
- `mem_rd`  out  1  read strobe, held until ack.
- `mem_wr`  out  1  write strobe, held until ack.
- `mem_wdata`  out  DW  latched write data.
- `mem_rdata`  in  DW  read data, valid when `mem_ack` is high.
- `mem_ack`  in  1  memory acknowledge.
- `dr_data`  out  DW  registered read word to DR.
- `dr_ld`  out  1  one-cycle load strobe to DR.

## Operation
- States: IDLE, RD_WAIT, WR_WAIT.
- IDLE, `rd_req`=1: latch `addr_in` into `mem_addr`, go to RD_WAIT, assert `mem_rd`.
- IDLE, `wr_req`=1 and `rd_req`=0: latch the address and `wr_data`, go to WR_WAIT, assert `mem_wr`.
- `rd_req` and `wr_req` together: the read wins. The write is dropped, not queued.
- Requests while `busy`=1 are ignored.
- RD_WAIT with `mem_ack`=1 at an edge:
  - `dr_data` <= `mem_rdata`.
  - `dr_ld`=1 and `done`=1 for the next cycle.
  - `mem_rd`=0; return to IDLE.
- WR_WAIT with `mem_ack`=1: `mem_wr`=0, `done`=1 for one cycle, return to IDLE. `dr_ld` stays 0.
- `mem_ack` is ignored in IDLE.
- `mem_addr`, `mem_wdata` and `dr_data` hold their value between transactions.
- `mem_rd` and `mem_wr` are never high together.

## Timing
- Reset (async, `rst_n`=0):
  - State goes to IDLE.
  - All outputs are 0, including `dr_data`, `mem_addr` and `mem_wdata`.
  - Reset mid-transaction drops the strobes immediately; no `dr_ld`, `done` or `err` follows.
- Request sampled at edge N: strobe is high from after N.
- Ack sampled at edge M ≥ N+1: `dr_ld`/`done` high for the cycle after M, and the strobe falls at M.
- Minimum read: `dr_ld` is high in the 2nd cycle after the request edge.
- `busy` falls at M, so the next request is sampled at edge M+1 at earliest. Peak rate is one transfer per 2 cycles.
- All outputs are registered; none is combinational from inputs.

## Configuration
- `DR_MEM_IF_TIMEOUT_EN` defined:
  - An 8-bit wait counter clears on request acceptance and increments each wait cycle without ack.
  - When the count reaches `TIMEOUT`-1 with no ack, the block aborts: strobe drops, `err`=1 for one cycle, return to IDLE.
  - On abort, `done`=0, `dr_ld`=0 and `dr_data` is unchanged.
  - Ack on the same edge as the timeout: ack wins and the transfer completes normally.
- Not defined: the block waits indefinitely, `err` is tied 0, and no counter is present.

## Test plan
- Read at addr 0x05, ack in the 1st wait cycle with rdata 0xBEEF -> `dr_data`=0xBEEF; `dr_ld` and `done` each high exactly 1 cycle; `mem_rd` high 1 cycle.
- Write 0x1234 to addr 0x0A, ack after 3 wait cycles -> `mem_wr` high 3 cycles with `mem_wdata`=0x1234 and `mem_addr`=0x0A; `done` high 1 cycle; `dr_ld` never high.
- `rd_req` and `wr_req` together at addr 0x3 -> read only; `mem_wr` stays 0. Requests pulsed while busy -> no second transaction.
- With `DR_MEM_IF_TIMEOUT_EN` and `TIMEOUT`=8, no ack -> `err` high 1 cycle after the 8th wait cycle; `dr_data` keeps its prior value. Ack on the final wait cycle -> normal completion, `err`=0.
- `rst_n` low during RD_WAIT -> `mem_rd`=0 at once (no clock needed); all outputs 0; no `dr_ld` after release.
